pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 38 +++
 rtl/pipeline_hazard_ctrl.sv | 116 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: hazard-detection inputs and stage control outputs.
// slave = controller side, master = pipeline/driver side.
interface pipeline_hazard_ctrl_if #(
  parameter int P_CNT_W = 16
);
  logic [4:0]         i_RS1Addr_D, i_RS2Addr_D;
  logic [4:0]         i_RS1Addr_E, i_RS2Addr_E;
  logic [4:0]         i_RDAddr_E, i_RDAddr_M, i_RDAddr_W;
  logic               i_RegWrite_E, i_RegWrite_M, i_RegWrite_W;
  logic               i_IsMemRead_E;
  logic               i_IsBranch_M, i_TakeBranch_M;
  logic               i_DMemBusy;
  logic               o_PcEn;
  logic               o_RegEn_D, o_RegEn_E, o_RegEn_M, o_RegEn_W;
  logic               o_RegClr_D, o_RegClr_E, o_RegClr_M, o_RegClr_W;
  logic [1:0]         o_FwdA_E, o_FwdB_E;
  logic [P_CNT_W-1:0] o_StallCnt;

  modport slave (
    input  i_RS1Addr_D, i_RS2Addr_D, i_RS1Addr_E, i_RS2Addr_E,
           i_RDAddr_E, i_RDAddr_M, i_RDAddr_W,
           i_RegWrite_E, i_RegWrite_M, i_RegWrite_W,
           i_IsMemRead_E, i_IsBranch_M, i_TakeBranch_M, i_DMemBusy,
    output o_PcEn, o_RegEn_D, o_RegEn_E, o_RegEn_M, o_RegEn_W,
           o_RegClr_D, o_RegClr_E, o_RegClr_M, o_RegClr_W,
           o_FwdA_E, o_FwdB_E, o_StallCnt
  );

  modport master (
    output i_RS1Addr_D, i_RS2Addr_D, i_RS1Addr_E, i_RS2Addr_E,
           i_RDAddr_E, i_RDAddr_M, i_RDAddr_W,
           i_RegWrite_E, i_RegWrite_M, i_RegWrite_W,
           i_IsMemRead_E, i_IsBranch_M, i_TakeBranch_M, i_DMemBusy,
    input  o_PcEn, o_RegEn_D, o_RegEn_E, o_RegEn_M, o_RegEn_W,
           o_RegClr_D, o_RegClr_E, o_RegClr_M, o_RegClr_W,
           o_FwdA_E, o_FwdB_E, o_StallCnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: stall/flush/forward decisions plus a
// saturating count of PC-stalled cycles.
module pipeline_hazard_ctrl #(
  parameter int P_FWD_EN       = 1,
  parameter int P_LOAD_BUBBLES = 1,
  parameter int P_IMEM_LAT     = 1,
  parameter int P_CNT_W        = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  logic [1:0]         fetch_cnt_q, fetch_cnt_d;
  logic [1:0]         lu_cnt_q, lu_cnt_d;
  logic [P_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       pc_en, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_m, clr_w;
  logic [1:0] fwd_a, fwd_b;
  logic       hit_e, hit_m, hit_w, load_use;

  function automatic logic src_hit(input logic [4:0] src, input logic [4:0] rd,
                                   input logic we);
    return we && (src == rd) && (src != 5'd0);
  endfunction

  always_comb begin
    hit_e = src_hit(bus.i_RS1Addr_D, bus.i_RDAddr_E, bus.i_RegWrite_E) |
            src_hit(bus.i_RS2Addr_D, bus.i_RDAddr_E, bus.i_RegWrite_E);
    hit_m = src_hit(bus.i_RS1Addr_D, bus.i_RDAddr_M, bus.i_RegWrite_M) |
            src_hit(bus.i_RS2Addr_D, bus.i_RDAddr_M, bus.i_RegWrite_M);
    hit_w = src_hit(bus.i_RS1Addr_D, bus.i_RDAddr_W, bus.i_RegWrite_W) |
            src_hit(bus.i_RS2Addr_D, bus.i_RDAddr_W, bus.i_RegWrite_W);
    load_use = bus.i_IsMemRead_E && hit_e;
  end

  always_comb begin
    pc_en = 1'b1;
    en_d = 1'b1; en_e = 1'b1; en_m = 1'b1; en_w = 1'b1;
    clr_d = 1'b0; clr_e = 1'b0; clr_m = 1'b0; clr_w = 1'b0;
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    fetch_cnt_d = fetch_cnt_q;
    lu_cnt_d    = lu_cnt_q;

    if (P_FWD_EN != 0) begin
      if (src_hit(bus.i_RS1Addr_E, bus.i_RDAddr_M, bus.i_RegWrite_M))      fwd_a = 2'b01;
      else if (src_hit(bus.i_RS1Addr_E, bus.i_RDAddr_W, bus.i_RegWrite_W)) fwd_a = 2'b10;
      if (src_hit(bus.i_RS2Addr_E, bus.i_RDAddr_M, bus.i_RegWrite_M))      fwd_b = 2'b01;
      else if (src_hit(bus.i_RS2Addr_E, bus.i_RDAddr_W, bus.i_RegWrite_W)) fwd_b = 2'b10;
    end

    // Fetch bubbles yield to any D-stall so the redirect count is not lost.
    if (bus.i_DMemBusy) begin
      pc_en = 1'b0;
      en_d = 1'b0; en_e = 1'b0; en_m = 1'b0;
      clr_w = 1'b1;
    end else if (bus.i_IsBranch_M && bus.i_TakeBranch_M) begin
      clr_d = 1'b1; clr_e = 1'b1; clr_m = 1'b1;
      fetch_cnt_d = 2'(P_IMEM_LAT);
      lu_cnt_d    = 2'd0;
    end else if ((P_FWD_EN != 0) && load_use) begin
      pc_en = 1'b0; en_d = 1'b0; clr_e = 1'b1;
      lu_cnt_d = 2'(P_LOAD_BUBBLES - 1);
    end else if ((P_FWD_EN == 0) && (hit_e || hit_m || hit_w)) begin
      pc_en = 1'b0; en_d = 1'b0; clr_e = 1'b1;
    end else if (lu_cnt_q != 2'd0) begin
      pc_en = 1'b0; en_d = 1'b0; clr_e = 1'b1;
      lu_cnt_d = lu_cnt_q - 2'd1;
    end else if (fetch_cnt_q != 2'd0) begin
      clr_d = 1'b1;
      fetch_cnt_d = fetch_cnt_q - 2'd1;
    end

    if (!i_Rst_n) begin
      pc_en = 1'b0;
      en_d = 1'b1; en_e = 1'b1; en_m = 1'b1; en_w = 1'b1;
      clr_d = 1'b1; clr_e = 1'b1; clr_m = 1'b1; clr_w = 1'b1;
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      fetch_cnt_d = 2'd0;
      lu_cnt_d    = 2'd0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + P_CNT_W'(1);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      fetch_cnt_q <= '0;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.o_PcEn     = pc_en;
  assign bus.o_RegEn_D  = en_d;
  assign bus.o_RegEn_E  = en_e;
  assign bus.o_RegEn_M  = en_m;
  assign bus.o_RegEn_W  = en_w;
  assign bus.o_RegClr_D = clr_d;
  assign bus.o_RegClr_E = clr_e;
  assign bus.o_RegClr_M = clr_m;
  assign bus.o_RegClr_W = clr_w;
  assign bus.o_FwdA_E   = fwd_a;
  assign bus.o_FwdB_E   = fwd_b;
  assign bus.o_StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a forwarding instance (2 load bubbles,
// 2 fetch bubbles) and a stall-only instance with a 4-bit stall counter.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.P_CNT_W(16)) bus0 ();
  pipeline_hazard_ctrl_if #(.P_CNT_W(4))  bus1 ();

  pipeline_hazard_ctrl #(.P_FWD_EN(1), .P_LOAD_BUBBLES(2), .P_IMEM_LAT(2), .P_CNT_W(16)) u_fwd (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus0));
  pipeline_hazard_ctrl #(.P_FWD_EN(0), .P_LOAD_BUBBLES(1), .P_IMEM_LAT(1), .P_CNT_W(4)) u_nofwd (
    .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus1));

  // {PcEn, RegEn D/E/M/W, RegClr D/E/M/W}
  localparam logic [8:0] C_DEF   = 9'b1_1111_0000;
  localparam logic [8:0] C_RST   = 9'b0_1111_1111;
  localparam logic [8:0] C_STALL = 9'b0_0111_0100;
  localparam logic [8:0] C_FLUSH = 9'b1_1111_1110;
  localparam logic [8:0] C_FBUB  = 9'b1_1111_1000;
  localparam logic [8:0] C_BUSY  = 9'b0_0001_0001;

  function automatic logic [8:0] ctl0();
    return {bus0.o_PcEn, bus0.o_RegEn_D, bus0.o_RegEn_E, bus0.o_RegEn_M, bus0.o_RegEn_W,
            bus0.o_RegClr_D, bus0.o_RegClr_E, bus0.o_RegClr_M, bus0.o_RegClr_W};
  endfunction

  function automatic logic [8:0] ctl1();
    return {bus1.o_PcEn, bus1.o_RegEn_D, bus1.o_RegEn_E, bus1.o_RegEn_M, bus1.o_RegEn_W,
            bus1.o_RegClr_D, bus1.o_RegClr_E, bus1.o_RegClr_M, bus1.o_RegClr_W};
  endfunction

  task automatic clear0();
    bus0.i_RS1Addr_D = '0; bus0.i_RS2Addr_D = '0; bus0.i_RS1Addr_E = '0; bus0.i_RS2Addr_E = '0;
    bus0.i_RDAddr_E = '0; bus0.i_RDAddr_M = '0; bus0.i_RDAddr_W = '0;
    bus0.i_RegWrite_E = 1'b0; bus0.i_RegWrite_M = 1'b0; bus0.i_RegWrite_W = 1'b0;
    bus0.i_IsMemRead_E = 1'b0; bus0.i_IsBranch_M = 1'b0; bus0.i_TakeBranch_M = 1'b0;
    bus0.i_DMemBusy = 1'b0;
  endtask

  task automatic clear1();
    bus1.i_RS1Addr_D = '0; bus1.i_RS2Addr_D = '0; bus1.i_RS1Addr_E = '0; bus1.i_RS2Addr_E = '0;
    bus1.i_RDAddr_E = '0; bus1.i_RDAddr_M = '0; bus1.i_RDAddr_W = '0;
    bus1.i_RegWrite_E = 1'b0; bus1.i_RegWrite_M = 1'b0; bus1.i_RegWrite_W = 1'b0;
    bus1.i_IsMemRead_E = 1'b0; bus1.i_IsBranch_M = 1'b0; bus1.i_TakeBranch_M = 1'b0;
    bus1.i_DMemBusy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear0(); clear1();
    bus0.i_RS1Addr_E = 5'd3; bus0.i_RDAddr_M = 5'd3; bus0.i_RegWrite_M = 1'b1;
    bus0.i_DMemBusy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_RST) begin n_fail++; $display("FAIL reset_ctl0: got %b exp %b", ctl0(), C_RST); end
    n_checks++;
    if (bus0.o_FwdA_E !== 2'b00) begin n_fail++; $display("FAIL reset_fwd: got %b exp 00", bus0.o_FwdA_E); end
    n_checks++;
    if (ctl1() !== C_RST || bus1.o_StallCnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_ctl1: got %b/%0d exp %b/0", ctl1(), bus1.o_StallCnt, C_RST);
    end
    clear0();
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_DEF || bus0.o_StallCnt !== 16'd0) begin
      n_fail++; $display("FAIL post_reset: got %b/%0d exp %b/0", ctl0(), bus0.o_StallCnt, C_DEF);
    end
    next_cycle();
  endtask

  task automatic test_forwarding();
    bus0.i_RS1Addr_E = 5'd3; bus0.i_RS2Addr_E = 5'd4;
    bus0.i_RDAddr_M = 5'd3; bus0.i_RegWrite_M = 1'b1;
    bus0.i_RDAddr_W = 5'd4; bus0.i_RegWrite_W = 1'b1;
    #1;
    n_checks++;
    if ({bus0.o_FwdA_E, bus0.o_FwdB_E} !== 4'b0110) begin
      n_fail++; $display("FAIL fwd_m_w: got %b%b exp 0110", bus0.o_FwdA_E, bus0.o_FwdB_E);
    end
    bus0.i_RS2Addr_E = 5'd3; bus0.i_RDAddr_W = 5'd3;
    #1;
    n_checks++;
    if ({bus0.o_FwdA_E, bus0.o_FwdB_E} !== 4'b0101) begin
      n_fail++; $display("FAIL fwd_m_prio: got %b%b exp 0101", bus0.o_FwdA_E, bus0.o_FwdB_E);
    end
    bus0.i_RS1Addr_E = 5'd0; bus0.i_RDAddr_M = 5'd0; bus0.i_RegWrite_W = 1'b0;
    #1;
    n_checks++;
    if ({bus0.o_FwdA_E, bus0.o_FwdB_E} !== 4'b0000 || ctl0() !== C_DEF) begin
      n_fail++; $display("FAIL fwd_x0_nowe: got %b%b/%b exp 0000/%b", bus0.o_FwdA_E, bus0.o_FwdB_E, ctl0(), C_DEF);
    end
    clear0();
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [15:0] base;
    base = bus0.o_StallCnt;
    bus0.i_IsMemRead_E = 1'b1; bus0.i_RDAddr_E = 5'd5; bus0.i_RegWrite_E = 1'b1;
    bus0.i_RS1Addr_D = 5'd5;
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_STALL) begin n_fail++; $display("FAIL lu_bubble1: got %b exp %b", ctl0(), C_STALL); end
    next_cycle();
    bus0.i_IsMemRead_E = 1'b0; bus0.i_RDAddr_E = 5'd0; bus0.i_RegWrite_E = 1'b0;
    bus0.i_RDAddr_M = 5'd5; bus0.i_RegWrite_M = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_STALL) begin n_fail++; $display("FAIL lu_bubble2: got %b exp %b", ctl0(), C_STALL); end
    next_cycle();
    bus0.i_RDAddr_M = 5'd0; bus0.i_RegWrite_M = 1'b0;
    bus0.i_RDAddr_W = 5'd5; bus0.i_RegWrite_W = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_DEF) begin n_fail++; $display("FAIL lu_release: got %b exp %b", ctl0(), C_DEF); end
    next_cycle();
    bus0.i_RS1Addr_D = 5'd0; bus0.i_RS1Addr_E = 5'd5;
    @(negedge clk);
    n_checks++;
    if (bus0.o_FwdA_E !== 2'b10 || ctl0() !== C_DEF) begin
      n_fail++; $display("FAIL lu_fwd_w: got %b/%b exp 10/%b", bus0.o_FwdA_E, ctl0(), C_DEF);
    end
    n_checks++;
    if (bus0.o_StallCnt !== base + 16'd2) begin
      n_fail++; $display("FAIL lu_stallcnt: got %0d exp %0d", bus0.o_StallCnt, base + 16'd2);
    end
    clear0();
    next_cycle();
  endtask

  task automatic test_branch();
    bus0.i_IsBranch_M = 1'b1; bus0.i_TakeBranch_M = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_DEF) begin n_fail++; $display("FAIL br_not_taken: got %b exp %b", ctl0(), C_DEF); end
    next_cycle();
    bus0.i_TakeBranch_M = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_FLUSH) begin n_fail++; $display("FAIL br_flush: got %b exp %b", ctl0(), C_FLUSH); end
    next_cycle();
    clear0();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctl0() !== C_FBUB) begin n_fail++; $display("FAIL br_fetch_bubble%0d: got %b exp %b", i, ctl0(), C_FBUB); end
      next_cycle();
    end
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_DEF) begin n_fail++; $display("FAIL br_done: got %b exp %b", ctl0(), C_DEF); end
    next_cycle();
  endtask

  task automatic test_branch_over_lu_and_busy();
    logic [15:0] base;
    base = bus0.o_StallCnt;
    bus0.i_IsMemRead_E = 1'b1; bus0.i_RDAddr_E = 5'd6; bus0.i_RegWrite_E = 1'b1;
    bus0.i_RS2Addr_D = 5'd6;
    next_cycle();
    clear0();
    bus0.i_IsBranch_M = 1'b1; bus0.i_TakeBranch_M = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_FLUSH) begin n_fail++; $display("FAIL br_over_lu: got %b exp %b", ctl0(), C_FLUSH); end
    next_cycle();
    clear0();
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_FBUB || bus0.o_StallCnt !== base + 16'd1) begin
      n_fail++; $display("FAIL lu_cleared: got %b/%0d exp %b/%0d", ctl0(), bus0.o_StallCnt, C_FBUB, base + 16'd1);
    end
    next_cycle();
    bus0.i_DMemBusy = 1'b1;
    bus0.i_RS1Addr_E = 5'd3; bus0.i_RDAddr_M = 5'd3; bus0.i_RegWrite_M = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctl0() !== C_BUSY || bus0.o_FwdA_E !== 2'b01) begin
        n_fail++; $display("FAIL busy%0d: got %b/%b exp %b/01", i, ctl0(), bus0.o_FwdA_E, C_BUSY);
      end
      next_cycle();
    end
    clear0();
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_FBUB || bus0.o_StallCnt !== base + 16'd4) begin
      n_fail++; $display("FAIL busy_hold: got %b/%0d exp %b/%0d", ctl0(), bus0.o_StallCnt, C_FBUB, base + 16'd4);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (ctl0() !== C_DEF) begin n_fail++; $display("FAIL busy_done: got %b exp %b", ctl0(), C_DEF); end
    next_cycle();
  endtask

  task automatic test_no_forward();
    bus1.i_RDAddr_M = 5'd7; bus1.i_RegWrite_M = 1'b1; bus1.i_RS1Addr_D = 5'd7;
    bus1.i_RS1Addr_E = 5'd7;
    @(negedge clk);
    n_checks++;
    if (ctl1() !== C_STALL || bus1.o_FwdA_E !== 2'b00) begin
      n_fail++; $display("FAIL nf_stall_m: got %b/%b exp %b/00", ctl1(), bus1.o_FwdA_E, C_STALL);
    end
    next_cycle();
    bus1.i_RDAddr_M = 5'd0; bus1.i_RegWrite_M = 1'b0;
    bus1.i_RDAddr_W = 5'd7; bus1.i_RegWrite_W = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl1() !== C_STALL) begin n_fail++; $display("FAIL nf_stall_w: got %b exp %b", ctl1(), C_STALL); end
    next_cycle();
    bus1.i_RDAddr_W = 5'd0; bus1.i_RegWrite_W = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ctl1() !== C_DEF || bus1.o_StallCnt !== 4'd2) begin
      n_fail++; $display("FAIL nf_release: got %b/%0d exp %b/2", ctl1(), bus1.o_StallCnt, C_DEF);
    end
    next_cycle();
    clear1();
    bus1.i_RDAddr_E = 5'd0; bus1.i_RegWrite_E = 1'b1;
    bus1.i_RS2Addr_D = 5'd9; bus1.i_RDAddr_M = 5'd9;
    @(negedge clk);
    n_checks++;
    if (ctl1() !== C_DEF) begin n_fail++; $display("FAIL nf_x0_nowe: got %b exp %b", ctl1(), C_DEF); end
    next_cycle();
    clear1();
  endtask

  task automatic test_saturate_and_reset();
    bus1.i_RDAddr_E = 5'd7; bus1.i_RegWrite_E = 1'b1; bus1.i_RS1Addr_D = 5'd7;
    for (int i = 0; i < 5; i++) next_cycle();
    n_checks++;
    if (bus1.o_StallCnt !== 4'd7) begin n_fail++; $display("FAIL sat_mid: got %0d exp 7", bus1.o_StallCnt); end
    for (int i = 0; i < 15; i++) next_cycle();
    n_checks++;
    if (bus1.o_StallCnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d exp 15", bus1.o_StallCnt); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus1.o_StallCnt !== 4'd0 || bus0.o_StallCnt !== 16'd0 || ctl1() !== C_RST) begin
      n_fail++; $display("FAIL async_rst: got %0d/%0d/%b exp 0/0/%b", bus1.o_StallCnt, bus0.o_StallCnt, ctl1(), C_RST);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ctl1() !== C_STALL || bus1.o_StallCnt !== 4'd0) begin
      n_fail++; $display("FAIL post_async: got %b/%0d exp %b/0", ctl1(), bus1.o_StallCnt, C_STALL);
    end
    next_cycle();
    n_checks++;
    if (bus1.o_StallCnt !== 4'd1) begin n_fail++; $display("FAIL restart_cnt: got %0d exp 1", bus1.o_StallCnt); end
    clear1();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_branch_over_lu_and_busy();
    test_no_forward();
    test_saturate_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
